// File: rtl/raisin64_pkg.sv
// Shared register-name constants and the tracked-register predicate for the raisin64 core.
package raisin64_pkg;

  localparam int unsigned RN_W           = 7;
  localparam int unsigned NUM_GPR        = 64;
  localparam int unsigned RN_SPECIAL_BIT = 6;

  // r0 and the special (non-GPR) namespace are never scoreboarded.
  function automatic logic rn_tracked(input logic [RN_W-1:0] rn);
    return (rn[RN_SPECIAL_BIT] == 1'b0) && (rn[5:0] != 6'd0);
  endfunction

endpackage

// File: rtl/reg_scoreboard_rn_onehot.sv
// Register name plus enable to a one-hot GPR mask; untracked names yield an all-zero mask.
module rn_onehot
  import raisin64_pkg::*;
(
  input  logic [RN_W-1:0]    rn,
  input  logic               en,
  output logic [NUM_GPR-1:0] mask
);

  always_comb begin
    mask = '0;
    if (en && rn_tracked(rn)) begin
      mask[rn[5:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: busy bits set on issue, cleared on writeback, with decode hazard check.
// Optional macro REG_SCOREBOARD_BYPASS_EN: hazard sees same-cycle writebacks and issues.
module reg_scoreboard #(
  parameter int unsigned NUM_WB = 6,
  parameter int unsigned RN_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RN_W-1:0]        rd_out_rn,
  input  logic                   rd_out_rn_en,
  input  logic [RN_W-1:0]        rd2_out_rn,
  input  logic                   rd2_out_rn_en,
  input  logic [RN_W*NUM_WB-1:0] wb_rn,
  input  logic [NUM_WB-1:0]      wb_en,
  input  logic [4*RN_W-1:0]      chk_rn,
  input  logic [3:0]             chk_en,
  output logic [63:0]            reg_busy,
  output logic                   hazard,
  output logic                   sb_err
);

  logic [63:0] set_m [2];
  logic [63:0] clr_m [NUM_WB];
  logic [63:0] chk_m [4];

  logic [63:0] set_mask, clr_mask, chk_mask, hz_view;
  logic [63:0] busy_d, busy_q;
  logic        sb_err_d, sb_err_q;

  rn_onehot u_set_rd  (.rn(rd_out_rn),  .en(rd_out_rn_en),  .mask(set_m[0]));
  rn_onehot u_set_rd2 (.rn(rd2_out_rn), .en(rd2_out_rn_en), .mask(set_m[1]));

  for (genvar g = 0; g < NUM_WB; g++) begin : g_clr
    rn_onehot u_clr (.rn(wb_rn[g*RN_W +: RN_W]), .en(wb_en[g]), .mask(clr_m[g]));
  end

  for (genvar g = 0; g < 4; g++) begin : g_chk
    rn_onehot u_chk (.rn(chk_rn[g*RN_W +: RN_W]), .en(chk_en[g]), .mask(chk_m[g]));
  end

  always_comb begin
    set_mask = set_m[0] | set_m[1];
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      clr_mask = clr_mask | clr_m[i];
    end
    chk_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      chk_mask = chk_mask | chk_m[i];
    end

    // Set after clear: a new producer supersedes the one writing back.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    // WAW issue, or writeback to a register nobody is producing.
    sb_err_d = sb_err_q
             | (|(set_mask & busy_q & ~clr_mask))
             | (|(clr_mask & ~busy_q & ~set_mask));

`ifdef REG_SCOREBOARD_BYPASS_EN
    hz_view = busy_d;
`else
    hz_view = busy_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign reg_busy = busy_q;
  assign sb_err   = sb_err_q;
  assign hazard   = ~rst & (|(chk_mask & hz_view));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (both REG_SCOREBOARD_BYPASS_EN builds).
module tb_reg_scoreboard;

  localparam int unsigned NUM_WB = 6;
  localparam int unsigned RN_W   = 7;

`ifdef REG_SCOREBOARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [RN_W-1:0]        rd_out_rn, rd2_out_rn;
  logic                   rd_out_rn_en, rd2_out_rn_en;
  logic [RN_W*NUM_WB-1:0] wb_rn;
  logic [NUM_WB-1:0]      wb_en;
  logic [4*RN_W-1:0]      chk_rn;
  logic [3:0]             chk_en;
  logic [63:0]            reg_busy;
  logic                   hazard;
  logic                   sb_err;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.NUM_WB(NUM_WB), .RN_W(RN_W)) dut (
    .clk(clk), .rst(rst),
    .rd_out_rn(rd_out_rn), .rd_out_rn_en(rd_out_rn_en),
    .rd2_out_rn(rd2_out_rn), .rd2_out_rn_en(rd2_out_rn_en),
    .wb_rn(wb_rn), .wb_en(wb_en),
    .chk_rn(chk_rn), .chk_en(chk_en),
    .reg_busy(reg_busy), .hazard(hazard), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_out_rn = '0; rd_out_rn_en = 1'b0;
    rd2_out_rn = '0; rd2_out_rn_en = 1'b0;
    wb_rn = '0; wb_en = '0;
    chk_rn = '0; chk_en = '0;
  endtask

  task automatic wb(input int unsigned port, input logic [6:0] rn);
    wb_rn[port*RN_W +: RN_W] = rn;
    wb_en[port] = 1'b1;
  endtask

  task automatic chk(input int unsigned slot, input logic [6:0] rn);
    chk_rn[slot*RN_W +: RN_W] = rn;
    chk_en[slot] = 1'b1;
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    chk(0, 7'd5);
    tick(); tick();
    check("rst_busy", reg_busy, 64'h0);
    check("rst_err", {63'b0, sb_err}, 64'h0);
    check("rst_hazard", {63'b0, hazard}, 64'h0);
    rst = 1'b0;
    idle();
    tick();
    check("idle_busy", reg_busy, 64'h0);

    // Basic set / clear latency.
    rd_out_rn = 7'd5; rd_out_rn_en = 1'b1;
    tick(); idle();
    check("set_r5", reg_busy, 64'h20);
    tick(); tick();
    wb(0, 7'd5);
    tick(); idle();
    check("clr_r5", reg_busy, 64'h0);
    check("clr_r5_err", {63'b0, sb_err}, 64'h0);

    // Untracked names: r0, special 0x45, writeback to r0.
    rd_out_rn = 7'd0; rd_out_rn_en = 1'b1;
    rd2_out_rn = 7'h45; rd2_out_rn_en = 1'b1;
    wb(1, 7'd0);
    chk(0, 7'd0);
    #1;
    check("hz_r0", {63'b0, hazard}, 64'h0);
    tick(); idle();
    check("untracked_busy", reg_busy, 64'h0);
    check("untracked_err", {63'b0, sb_err}, 64'h0);

    // Set wins over clear on the same register.
    rd_out_rn = 7'd9; rd_out_rn_en = 1'b1;
    tick(); idle();
    check("set_r9", reg_busy, 64'h200);
    rd_out_rn = 7'd9; rd_out_rn_en = 1'b1;
    wb(1, 7'd9);
    tick(); idle();
    check("setclr_r9", reg_busy, 64'h200);
    check("setclr_r9_err", {63'b0, sb_err}, 64'h0);

    // Advint dual destination, cleared by two ports together.
    rd_out_rn = 7'd3; rd_out_rn_en = 1'b1;
    rd2_out_rn = 7'd4; rd2_out_rn_en = 1'b1;
    tick(); idle();
    check("set_r3r4", reg_busy, 64'h218);
    wb(2, 7'd3); wb(3, 7'd4);
    tick(); idle();
    check("clr_r3r4", reg_busy, 64'h200);
    wb(4, 7'd9); wb(5, 7'd9);
    tick(); idle();
    check("dup_clr_r9", reg_busy, 64'h0);
    check("dup_clr_err", {63'b0, sb_err}, 64'h0);

    // Hazard with same-cycle writeback.
    rd_out_rn = 7'd10; rd_out_rn_en = 1'b1;
    tick(); idle();
    wb(0, 7'd10); chk(1, 7'd10);
    #1;
    check("hz_wb_bypass", {63'b0, hazard}, {63'b0, ~BYP});
    tick(); idle();
    check("clr_r10", reg_busy, 64'h0);

    // Registered hazard, untracked check name, disabled slot, same-cycle issue.
    rd_out_rn = 7'd11; rd_out_rn_en = 1'b1;
    tick(); idle();
    chk(0, 7'd11);
    #1;
    check("hz_r11", {63'b0, hazard}, 64'h1);
    idle(); chk(0, 7'h4B);
    #1;
    check("hz_special", {63'b0, hazard}, 64'h0);
    idle();
    chk_rn[1*RN_W +: RN_W] = 7'd11;
    rd_out_rn = 7'd12; rd_out_rn_en = 1'b1; chk(2, 7'd12);
    #1;
    check("hz_issue_bypass", {63'b0, hazard}, {63'b0, BYP});
    tick(); idle();
    check("set_r11r12", reg_busy, 64'h1800);
    wb(0, 7'd11); wb(5, 7'd12);
    tick(); idle();
    check("clr_r11r12", reg_busy, 64'h0);
    check("clr_r11r12_err", {63'b0, sb_err}, 64'h0);

    // WAW sets the sticky error; only reset clears it.
    rd_out_rn = 7'd7; rd_out_rn_en = 1'b1;
    tick();
    check("waw_first_err", {63'b0, sb_err}, 64'h0);
    tick(); idle();
    check("waw_err", {63'b0, sb_err}, 64'h1);
    check("waw_busy", reg_busy, 64'h80);
    tick(); tick();
    check("waw_sticky", {63'b0, sb_err}, 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("waw_rst_err", {63'b0, sb_err}, 64'h0);
    check("waw_rst_busy", reg_busy, 64'h0);

    // Writeback to an idle register.
    wb(0, 7'd8);
    tick(); idle();
    check("orphan_err", {63'b0, sb_err}, 64'h1);
    check("orphan_busy", reg_busy, 64'h0);

    // Mid-operation reset drops busy bits and discards writebacks.
    rst = 1'b1; tick(); rst = 1'b0;
    rd_out_rn = 7'd20; rd_out_rn_en = 1'b1;
    tick(); idle();
    check("set_r20", reg_busy, 64'h0010_0000);
    rst = 1'b1;
    wb(0, 7'd21); chk(0, 7'd20);
    #1;
    check("hz_in_rst", {63'b0, hazard}, 64'h0);
    tick(); idle();
    rst = 1'b0;
    tick();
    check("rst_mid_busy", reg_busy, 64'h0);
    check("rst_mid_err", {63'b0, sb_err}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
